// File: rtl/snax_csr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : snax_csr_responder                                              |
// | Purpose  : SNAX CSR endpoint: RW/RO CSR bank, in-order read-response FIFO  |
// |            and launch/busy control of the attached accelerator.            |
// | Options  : SNAX_CSR_RESPONDER_PERF_CNT_EN adds a busy-cycle counter        |
// |            readable at PerfAddr.                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module snax_csr_responder #(
    parameter int unsigned NumRwCsr     = 4,
    parameter int unsigned NumRoCsr     = 2,
    parameter int unsigned RspFifoDepth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               csr_req_data_i,
    input  logic [31:0]               csr_req_addr_i,
    input  logic                      csr_req_write_i,
    input  logic                      csr_req_valid_i,
    output logic                      csr_req_ready_o,
    output logic [31:0]               csr_rsp_data_o,
    output logic                      csr_rsp_valid_o,
    input  logic                      csr_rsp_ready_i,
    output logic [NumRwCsr-1:0][31:0] register_rw_o,
    input  logic [NumRoCsr-1:0][31:0] register_ro_i,
    output logic                      acc_start_valid_o,
    input  logic                      acc_start_ready_i,
    input  logic                      acc_done_i
);

    localparam int unsigned CtrlAddr = NumRwCsr + NumRoCsr;
    localparam int unsigned PtrW     = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned CntW     = $clog2(RspFifoDepth + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [NumRwCsr-1:0][31:0]    register_rw_q, register_rw_d;
    logic [RspFifoDepth-1:0][31:0] fifo_q, fifo_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              fifo_cnt_q, fifo_cnt_d;

    logic [NumRwCsr-1:0] rw_hit;
    logic [NumRoCsr-1:0] ro_hit;
    logic                addr_is_rw;
    logic                addr_is_ctrl;
    logic                busy;
    logic                wr_stall;
    logic                rd_stall;
    logic                req_fire;
    logic                wr_fire;
    logic                rd_fire;
    logic                start_fire;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [31:0]         rd_data;

    // Address decode compares the full 32-bit index so aliases never hit.
    for (genvar g = 0; g < NumRwCsr; g++) begin : g_rw_hit
        assign rw_hit[g] = (csr_req_addr_i == 32'(g));
    end

    for (genvar g = 0; g < NumRoCsr; g++) begin : g_ro_hit
        assign ro_hit[g] = (csr_req_addr_i == 32'(NumRwCsr + g));
    end

    assign addr_is_rw   = |rw_hit;
    assign addr_is_ctrl = (csr_req_addr_i == 32'(CtrlAddr));

`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
    localparam int unsigned PerfAddr = CtrlAddr + 1;

    logic        addr_is_perf;
    logic [31:0] perf_cnt_q, perf_cnt_d;

    assign addr_is_perf = (csr_req_addr_i == 32'(PerfAddr));

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (start_fire) begin
            perf_cnt_d = '0;
        end else if (busy && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end
`endif

    assign busy = (state_q != IDLE);

    // Ready only looks at registered state, never at csr_rsp_ready_i.
    assign wr_stall        = csr_req_write_i && (addr_is_rw || addr_is_ctrl) && busy;
    assign rd_stall        = !csr_req_write_i && fifo_full;
    assign csr_req_ready_o = !(wr_stall || rd_stall);

    assign req_fire   = csr_req_valid_i && csr_req_ready_o;
    assign wr_fire    = req_fire && csr_req_write_i;
    assign rd_fire    = req_fire && !csr_req_write_i;
    assign start_fire = wr_fire && addr_is_ctrl && csr_req_data_i[0];

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NumRwCsr; i++) begin
            if (rw_hit[i]) rd_data = register_rw_q[i];
        end
        for (int unsigned i = 0; i < NumRoCsr; i++) begin
            if (ro_hit[i]) rd_data = register_ro_i[i];
        end
        if (addr_is_ctrl) rd_data = {31'b0, busy};
`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
        if (addr_is_perf) rd_data = perf_cnt_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_fire) state_d = LAUNCH;
            LAUNCH:  if (acc_start_ready_i) state_d = BUSY;
            BUSY:    if (acc_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_start_valid_o = (state_q == LAUNCH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        register_rw_d = register_rw_q;
        for (int unsigned i = 0; i < NumRwCsr; i++) begin
            if (wr_fire && rw_hit[i]) register_rw_d[i] = csr_req_data_i;
        end
    end

    assign register_rw_o = register_rw_q;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        if (p == PtrW'(RspFifoDepth - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign fifo_full  = (fifo_cnt_q == CntW'(RspFifoDepth));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_push  = rd_fire;
    assign fifo_pop   = !fifo_empty && csr_rsp_ready_i;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            fifo_d[wr_ptr_q] = rd_data;
            wr_ptr_d         = ptr_next(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    assign csr_rsp_valid_o = !fifo_empty;
    assign csr_rsp_data_o  = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            register_rw_q <= '0;
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            register_rw_q <= register_rw_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snax_csr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_snax_csr_responder                                           |
// | Purpose  : Self-checking bench for snax_csr_responder (default params).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_snax_csr_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      req_data, req_addr;
    logic             req_write, req_valid, req_ready;
    logic [31:0]      rsp_data;
    logic             rsp_valid, rsp_ready;
    logic [3:0][31:0] reg_rw;
    logic [1:0][31:0] reg_ro;
    logic             start_valid, start_ready, done;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
    localparam logic [31:0] PERF_EXP = 32'd12;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    snax_csr_responder #(
        .NumRwCsr    (4),
        .NumRoCsr    (2),
        .RspFifoDepth(2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .csr_req_data_i   (req_data),
        .csr_req_addr_i   (req_addr),
        .csr_req_write_i  (req_write),
        .csr_req_valid_i  (req_valid),
        .csr_req_ready_o  (req_ready),
        .csr_rsp_data_o   (rsp_data),
        .csr_rsp_valid_o  (rsp_valid),
        .csr_rsp_ready_i  (rsp_ready),
        .register_rw_o    (reg_rw),
        .register_ro_i    (reg_ro),
        .acc_start_valid_o(start_valid),
        .acc_start_ready_i(start_ready),
        .acc_done_i       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: CSR array, response queue, abstract mode (0 idle, 1 launch, 2 busy).
    logic [31:0] m_regs [4] = '{default: 32'd0};
    logic [31:0] m_q [$];
    int          m_state = 0;
    logic [31:0] m_perf = 32'd0;
    logic        m_rdy, m_acc;
    logic [31:0] m_rv;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a < 32'd4) return m_regs[a[1:0]];
        if (a == 32'd4) return reg_ro[0];
        if (a == 32'd5) return reg_ro[1];
        if (a == 32'd6) return (m_state != 0) ? 32'd1 : 32'd0;
`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
        if (a == 32'd7) return m_perf;
`endif
        return 32'd0;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_state = 0;
            m_perf  = 32'd0;
            m_q.delete();
            for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
        end else begin
            if (req_write) m_rdy = !(((req_addr < 32'd4) || (req_addr == 32'd6)) && (m_state != 0));
            else           m_rdy = (m_q.size() < 2);
            chk("mon_req_ready", {31'b0, req_ready}, {31'b0, m_rdy});
            chk("mon_rsp_valid", {31'b0, rsp_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
            if (m_q.size() != 0) chk("mon_rsp_data", rsp_data, m_q[0]);
            chk("mon_start_valid", {31'b0, start_valid}, (m_state == 1) ? 32'd1 : 32'd0);
            for (int i = 0; i < 4; i++) chk($sformatf("mon_reg_rw%0d", i), reg_rw[i], m_regs[i]);

            m_acc = req_valid && m_rdy;
            m_rv  = ref_read(req_addr);
            if ((m_q.size() != 0) && rsp_ready) void'(m_q.pop_front());
            if (m_acc && !req_write) m_q.push_back(m_rv);
            if (m_acc && req_write && (req_addr < 32'd4)) m_regs[req_addr[1:0]] = req_data;
`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
            if (m_acc && req_write && (req_addr == 32'd6) && req_data[0]) m_perf = 32'd0;
            else if ((m_state != 0) && (m_perf != 32'hFFFF_FFFF)) m_perf = m_perf + 32'd1;
`endif
            case (m_state)
                0: if (m_acc && req_write && (req_addr == 32'd6) && req_data[0]) m_state = 1;
                1: if (start_ready) m_state = 2;
                2: if (done) m_state = 0;
                default: m_state = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until accepted; returns one step after the accepting edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit ok = 0;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (req_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: addr %h not accepted within 40 cycles, expected acceptance", a);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam int NTBL = 19;
    vec_t tbl [NTBL];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'd1,          32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b0, 32'd1,          32'd0,         32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'd0,          32'h1234_5678, 32'h1234_5678};
        tbl[3]  = '{1'b1, 32'd3,          32'hA5A5_5A5A, 32'hA5A5_5A5A};
        tbl[4]  = '{1'b0, 32'd0,          32'd0,         32'h1234_5678};
        tbl[5]  = '{1'b0, 32'd3,          32'd0,         32'hA5A5_5A5A};
        tbl[6]  = '{1'b0, 32'd2,          32'd0,         32'd0};
        tbl[7]  = '{1'b0, 32'd4,          32'd0,         32'h4444_0004};
        tbl[8]  = '{1'b0, 32'd5,          32'd0,         32'h5555_0005};
        tbl[9]  = '{1'b0, 32'd6,          32'd0,         32'd0};
        tbl[10] = '{1'b0, 32'h100,        32'd0,         32'd0};
        tbl[11] = '{1'b1, 32'd4,          32'hFFFF_FFFF, 32'd0};
        tbl[12] = '{1'b0, 32'd4,          32'd0,         32'h4444_0004};
        tbl[13] = '{1'b1, 32'd7,          32'h77,        32'd0};
        tbl[14] = '{1'b0, 32'd7,          32'd0,         32'd0};
        tbl[15] = '{1'b1, 32'd6,          32'd2,         32'd0};
        tbl[16] = '{1'b0, 32'd6,          32'd0,         32'd0};
        tbl[17] = '{1'b0, 32'hFFFF_FFFF,  32'd0,         32'd0};
        tbl[18] = '{1'b0, 32'h8000_0001,  32'd0,         32'd0};

        rst = 1'b1; req_data = '0; req_addr = '0; req_write = 1'b0; req_valid = 1'b0;
        rsp_ready = 1'b1; reg_ro[0] = 32'h4444_0004; reg_ro[1] = 32'h5555_0005;
        start_ready = 1'b0; done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_start_valid", {31'b0, start_valid}, 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_reg_rw%0d", i), reg_rw[i], 32'd0);
        tick();

        for (int i = 0; i < NTBL; i++) begin
            do_req(tbl[i].w, tbl[i].addr, tbl[i].data);
            if (!tbl[i].w) begin
                chk($sformatf("tbl%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
                chk($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].exp);
            end else if (tbl[i].addr < 32'd4) begin
                chk($sformatf("tbl%0d_reg", i), reg_rw[tbl[i].addr[1:0]], tbl[i].exp);
            end else begin
                chk($sformatf("tbl%0d_no_rsp", i), {31'b0, rsp_valid}, 32'd0);
            end
            tick();
        end

        // Response backpressure: two reads fill the FIFO, the third stalls.
        rsp_ready = 1'b0;
        reg_ro[0] = 32'hAAAA_0004;
        do_req(1'b0, 32'd4, 32'd0);
        reg_ro[0] = 32'hBBBB_0000; reg_ro[1] = 32'hCCCC_0005;
        do_req(1'b0, 32'd5, 32'd0);
        reg_ro[1] = 32'hDDDD_0000;
        req_write = 1'b0; req_addr = 32'd0; req_valid = 1'b1;
        #1;
        chk("bp_stall", {31'b0, req_ready}, 32'd0);
        chk("bp_head0", rsp_data, 32'hAAAA_0004);
        tick();
        #1;
        chk("bp_stall2", {31'b0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_full_no_bypass", {31'b0, req_ready}, 32'd0);
        tick();
        #1;
        chk("bp_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_head1", rsp_data, 32'hCCCC_0005);
        tick();
        req_valid = 1'b0;
        chk("bp_valid2", {31'b0, rsp_valid}, 32'd1);
        chk("bp_head2", rsp_data, 32'h1234_5678);
        tick();
        chk("bp_empty", {31'b0, rsp_valid}, 32'd0);

        // Launch with a delayed start handshake, then a write stalled by BUSY.
        start_ready = 1'b0;
        do_req(1'b1, 32'd6, 32'd1);
        chk("launch_n1", {31'b0, start_valid}, 32'd1);
        tick(); chk("launch_hold1", {31'b0, start_valid}, 32'd1);
        tick(); chk("launch_hold2", {31'b0, start_valid}, 32'd1);
        start_ready = 1'b1;
        tick();
        start_ready = 1'b0;
        chk("launch_drop", {31'b0, start_valid}, 32'd0);
        do_req(1'b0, 32'd6, 32'd0);
        chk("ctrl_busy_rsp", rsp_data, 32'd1);
        tick();
        req_write = 1'b1; req_addr = 32'd0; req_data = 32'hCAFE_0000; req_valid = 1'b1;
        #1;
        chk("busy_wr_stall", {31'b0, req_ready}, 32'd0);
        tick();
        #1;
        chk("busy_wr_stall2", {31'b0, req_ready}, 32'd0);
        done = 1'b1;
        #1;
        chk("busy_wr_stall_done", {31'b0, req_ready}, 32'd0);
        tick();
        done = 1'b0;
        #1;
        chk("stall_release", {31'b0, req_ready}, 32'd1);
        chk("reg0_before", reg_rw[0], 32'h1234_5678);
        tick();
        req_valid = 1'b0;
        chk("reg0_after", reg_rw[0], 32'hCAFE_0000);
        do_req(1'b0, 32'd6, 32'd0);
        chk("ctrl_idle_rsp", rsp_data, 32'd0);
        tick();

        // Busy-cycle counter: 2 LAUNCH cycles (done ignored there) + 10 BUSY cycles.
        start_ready = 1'b0;
        do_req(1'b1, 32'd6, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_in_launch", {31'b0, start_valid}, 32'd1);
        start_ready = 1'b1;
        tick();
        start_ready = 1'b0;
        repeat (9) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        do_req(1'b0, 32'd7, 32'd0);
        chk("perf_rsp", rsp_data, PERF_EXP);
        tick();

        // Reset while BUSY with two queued responses.
        rsp_ready = 1'b0; start_ready = 1'b1;
        do_req(1'b1, 32'd6, 32'd1);
        tick();
        do_req(1'b0, 32'd1, 32'd0);
        do_req(1'b0, 32'd2, 32'd0);
        #1;
        chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        chk("pre_rst_full", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_start_valid", {31'b0, start_valid}, 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_reg%0d", i), reg_rw[i], 32'd0);
        #1;
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // Random traffic checked by the reference model.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel       = int'($urandom_range(0, 9));
            req_valid = ($urandom_range(0, 99) < 60);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = (sel < 8) ? 32'(sel) : ((sel == 8) ? 32'h100 : $urandom);
            req_data  = $urandom;
            rsp_ready = ($urandom_range(0, 99) < 70);
            start_ready = 1'($urandom_range(0, 1));
            done      = ($urandom_range(0, 99) < 15);
            reg_ro[0] = $urandom;
            reg_ro[1] = $urandom;
            tick();
        end
        req_valid = 1'b0; done = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
